intc: RTL and testbench

- PICO16a bus-slave interrupt controller: the receiving end of the peripheral `int_req` lines (timer and others). It also produces the per-source acknowledge that peripherals otherwise get through their own registers.
- Masks and prioritises up to 8 sources and raises a single CPU interrupt.
- The CPU claims an interrupt by reading the vector register and releases it by writing end-of-interrupt (EOI).
- Sits on the same chip-select/address/data bus as the other peripherals.

---
 rtl/intc.sv | 185 ++++++++++++++++++
 tb/tb_intc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intc.sv
// rtl/intc.sv - PICO16a bus-slave interrupt controller: mask, prioritise, claim via VECTOR, release via EOI.
// Optional build macro IRQ_EDGE_EN: per-source rising-edge pending latches instead of level sensing.
module intc #(
  parameter int NUM_IRQ = 8
) (
  input  logic               cpu_clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               we,
  input  logic [2:0]         adrs,
  input  logic [15:0]        from_cpu,
  output logic [15:0]        to_cpu,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               int_req,
  output logic [NUM_IRQ-1:0] irq_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam logic [2:0] A_MASK = 3'b000;
  localparam logic [2:0] A_PEND = 3'b001;
  localparam logic [2:0] A_VEC  = 3'b010;
  localparam logic [2:0] A_CTRL = 3'b011;
  localparam logic [2:0] A_EOI  = 3'b100;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_IRQ-1:0] r_mask;
  logic               r_gen;
  logic [2:0]         r_svc_id;
  logic               w_svc_load;
  logic               w_ack_fire;
  logic [NUM_IRQ-1:0] w_src;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_svc_onehot;
  logic [2:0]         w_enc;
  logic               w_claim;
  logic               w_eoi;
  logic               w_mask_wr;
  logic               w_ctrl_wr;
  logic [15:0]        w_rdata;
  logic [15:0]        w_vec;
  logic [2:0]         w_vec_id;
  logic               w_unused;

  assign w_unused  = ^from_cpu;
  assign w_claim   = cs & ~we & (adrs == A_VEC);
  assign w_eoi     = cs &  we & (adrs == A_EOI);
  assign w_mask_wr = cs &  we & (adrs == A_MASK);
  assign w_ctrl_wr = cs &  we & (adrs == A_CTRL);

  always_comb begin
    w_svc_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_svc_onehot[i] = (r_svc_id == 3'(i));
    end
  end

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] r_irq_d;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_clr;

  assign w_clr = (r_state == SERV && w_eoi) ? w_svc_onehot : '0;

  // Latches capture edges regardless of mask; a new edge beats a same-cycle EOI clear.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      r_irq_d <= '0;
      r_pend  <= '0;
    end else begin
      r_irq_d <= irq_in;
      r_pend  <= (r_pend & ~w_clr) | (irq_in & ~r_irq_d);
    end
  end

  assign w_src = r_pend;
`else
  assign w_src = irq_in;
`endif

  assign w_active = w_src & r_mask;

  always_comb begin
    w_enc = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_enc = 3'(i);
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_svc_load  = 1'b0;
    w_ack_fire  = 1'b0;
    int_req     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_gen && (|w_active)) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        int_req = 1'b1;
        if (w_claim) begin
          w_state_nxt = SERV;
          w_svc_load  = 1'b1;
        end else if (!r_gen || (w_active == '0)) begin
          w_state_nxt = IDLE;
        end
      end
      SERV: begin
        if (w_eoi) begin
          w_state_nxt = IDLE;
          w_ack_fire  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      r_mask   <= '0;
      r_gen    <= 1'b0;
      r_svc_id <= 3'd0;
      irq_ack  <= '0;
    end else begin
      if (w_mask_wr) begin
        r_mask <= from_cpu[NUM_IRQ-1:0];
      end
      if (w_ctrl_wr) begin
        r_gen <= from_cpu[0];
      end
      if (w_svc_load) begin
        r_svc_id <= w_enc;
      end
      irq_ack <= w_ack_fire ? w_svc_onehot : '0;
    end
  end

  // Vector fields come from pre-update state, so the claiming read still shows REQ.
  assign w_vec_id = (r_state == SERV) ? r_svc_id : w_enc;
  assign w_vec    = (r_state == IDLE) ? 16'h0000
                  : {1'b1, (r_state == SERV), 11'b0, w_vec_id};

  always_comb begin
    w_rdata = 16'h0000;
    case (adrs)
      A_MASK: w_rdata = {{(16-NUM_IRQ){1'b0}}, r_mask};
`ifdef IRQ_EDGE_EN
      A_PEND: w_rdata = {{(16-NUM_IRQ){1'b0}}, r_pend};
`else
      A_PEND: w_rdata = {{(16-NUM_IRQ){1'b0}}, w_active};
`endif
      A_VEC:  w_rdata = w_vec;
      A_CTRL: w_rdata = {8'b0, int_req, 4'b0, (r_state == SERV), (r_state == REQ), r_gen};
      default: w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      to_cpu <= 16'h0000;
    end else begin
      to_cpu <= w_rdata;
    end
  end

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - randomized and directed self-checking bench for intc against a behavioural model.
module tb_intc;

  logic        cpu_clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [2:0]  adrs;
  logic [15:0] from_cpu;
  logic [15:0] to_cpu;
  logic [7:0]  irq_in;
  logic        int_req;
  logic [7:0]  irq_ack;

  int n_checks;
  int n_errors;

`ifdef IRQ_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  // Behavioural model: phase 0 idle, 1 requesting, 2 in service
  int m_phase;
  int m_mask;
  int m_gen;
  int m_svc;
  int m_pend;
  int m_prev;
  int e_rd;
  int e_ack;
  int e_int;

  intc #(.NUM_IRQ(8)) dut (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .cs      (cs),
    .we      (we),
    .adrs    (adrs),
    .from_cpu(from_cpu),
    .to_cpu  (to_cpu),
    .irq_in  (irq_in),
    .int_req (int_req),
    .irq_ack (irq_ack)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input int v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic step(input logic c, input logic w, input logic [2:0] a,
                      input logic [15:0] d, input logic [7:0] irq);
    int act;
    int enc;
    bit claim;
    bit eoi;
    int clr;
    act   = (EDGE ? m_pend : int'(irq)) & m_mask;
    enc   = lowest(act);
    claim = c && !w && a == 3'd2;
    eoi   = c && w && a == 3'd4;
    case (a)
      3'd0: e_rd = m_mask;
      3'd1: e_rd = EDGE ? m_pend : act;
      3'd2: e_rd = (m_phase == 0) ? 0
                 : (32'h8000 | ((m_phase == 2) ? 32'h4000 : 0) | ((m_phase == 2) ? m_svc : enc));
      3'd3: e_rd = ((m_phase == 1) ? 32'h80 : 0) | ((m_phase == 2) ? 4 : 0)
                 | ((m_phase == 1) ? 2 : 0) | m_gen;
      default: e_rd = 0;
    endcase
    e_ack = 0;
    clr   = 0;
    if (m_phase == 0) begin
      if (m_gen != 0 && act != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (claim) begin
        m_phase = 2;
        m_svc   = enc;
      end else if (m_gen == 0 || act == 0) begin
        m_phase = 0;
      end
    end else if (eoi) begin
      m_phase = 0;
      e_ack   = 1 << m_svc;
      clr     = 1 << m_svc;
    end
    m_pend = (m_pend & ~clr) | (int'(irq) & ~m_prev & 32'hFF);
    m_prev = int'(irq);
    if (c && w && a == 3'd0) m_mask = int'(d[7:0]);
    if (c && w && a == 3'd3) m_gen = int'(d[0]);
    e_int = (m_phase == 1) ? 1 : 0;

    cs = c; we = w; adrs = a; from_cpu = d; irq_in = irq;
    @(posedge cpu_clk);
    #1;
    check("to_cpu", int'(to_cpu), e_rd);
    check("irq_ack", int'(irq_ack), e_ack);
    check("int_req", int'(int_req), e_int);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_phase = 0; m_mask = 0; m_gen = 0; m_svc = 0; m_pend = 0; m_prev = 0;
    cs = 1'b1; we = 1'b1; adrs = 3'd0; from_cpu = 16'h00FF; irq_in = 8'h00;
    @(posedge cpu_clk);
    #1;
    check("rst_to_cpu", int'(to_cpu), 0);
    check("rst_int_req", int'(int_req), 0);
    check("rst_irq_ack", int'(irq_ack), 0);
    cs = 1'b0; we = 1'b0;
    rst = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [7:0] irq);
    step(1'b1, 1'b1, a, d, irq);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] irq);
    step(1'b1, 1'b0, a, 16'h0000, irq);
  endtask

  task automatic idle(input logic [7:0] irq);
    step(1'b0, 1'b0, 3'd0, 16'h0000, irq);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    cs = 1'b0; we = 1'b0; adrs = 3'd0; from_cpu = 16'h0; irq_in = 8'h0;
    #2;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 8'h00);
      check("reset_reg", int'(to_cpu), 0);
    end

`ifdef IRQ_EDGE_EN
    wr(3'd3, 16'h0001, 8'h00);
    idle(8'h20);
    idle(8'h00);
    rd(3'd1, 8'h00);
    check("edge_pend", int'(to_cpu), 16'h0020);
    check("edge_noreq", int'(int_req), 0);
    wr(3'd0, 16'h0020, 8'h00);
    idle(8'h00);
    check("edge_req", int'(int_req), 1);
    rd(3'd2, 8'h00);
    check("edge_vec", int'(to_cpu), 16'h8005);
    wr(3'd4, 16'h0000, 8'h00);
    check("edge_ack", int'(irq_ack), 8'h20);
    rd(3'd1, 8'h00);
    check("edge_pend_clr", int'(to_cpu), 0);
    idle(8'h00);
    check("edge_no_rereq", int'(int_req), 0);
`else
    wr(3'd0, 16'h0004, 8'h00);
    wr(3'd3, 16'h0001, 8'h00);
    idle(8'h04);
    check("lat_req", int'(int_req), 1);
    rd(3'd2, 8'h04);
    check("claim_vec", int'(to_cpu), 16'h8002);
    check("claim_intreq", int'(int_req), 0);
    rd(3'd2, 8'h04);
    check("serv_vec", int'(to_cpu), 16'hC002);
    wr(3'd4, 16'h0000, 8'h04);
    check("eoi_ack", int'(irq_ack), 8'h04);
    check("eoi_idle", int'(int_req), 0);
    idle(8'h04);
    check("ack_1cyc", int'(irq_ack), 0);
    check("rereq", int'(int_req), 1);
    rd(3'd2, 8'h04);
    wr(3'd4, 16'h0000, 8'h00);

    wr(3'd0, 16'h00FF, 8'h00);
    idle(8'h0A);
    rd(3'd2, 8'h0A);
    check("prio_vec", int'(to_cpu), 16'h8001);
    idle(8'h08);
    wr(3'd4, 16'h0000, 8'h08);
    check("prio_ack", int'(irq_ack), 8'h02);
    idle(8'h08);
    rd(3'd2, 8'h08);
    check("prio_vec2", int'(to_cpu), 16'h8003);
    wr(3'd4, 16'h0000, 8'h00);
    check("prio_ack2", int'(irq_ack), 8'h08);

    idle(8'h01);
    check("wd_req", int'(int_req), 1);
    idle(8'h00);
    check("wd_idle", int'(int_req), 0);
    rd(3'd2, 8'h00);
    check("wd_vec", int'(to_cpu), 0);
    wr(3'd4, 16'h0000, 8'h00);
    check("wd_noack", int'(irq_ack), 0);

    idle(8'h01);
    rd(3'd2, 8'h01);
    wr(3'd0, 16'h0000, 8'h01);
    wr(3'd3, 16'h0000, 8'h01);
    rd(3'd3, 8'h01);
    check("serv_ctrl", int'(to_cpu), 16'h0004);
    wr(3'd4, 16'h0000, 8'h01);
    check("serv_ack", int'(irq_ack), 8'h01);
    idle(8'h01);
    idle(8'h01);
    check("masked_noreq", int'(int_req), 0);

    wr(3'd0, 16'h0001, 8'h01);
    wr(3'd3, 16'h0001, 8'h01);
    idle(8'h01);
    rd(3'd2, 8'h01);
    do_reset();
    idle(8'h00);
    check("abort_noack", int'(irq_ack), 0);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic c, w;
      logic [2:0] a;
      logic [15:0] d;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      c = ($urandom_range(0, 2) != 0);
      w = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        irq_in = 8'($urandom) & 8'($urandom);
      end
      step(c, w, a, d, irq_in);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
